gpr_access_ctrl: RTL

Sequencer on the initiator side of the GPR file's read/write port. Accepts one decoded register-operation at a time, issues the registered GPR read, presents operands to the execute unit with a valid/ready handshake, collects the result (low byte plus multiply-high byte) and issues the GPR write-back. Sits between the decoder and the register file / ALU in the 8-bit datapath.

---
 rtl/gpr_access_ctrl_pkg.sv | 15 +
 rtl/gpr_bypass_mux.sv | 53 +++++
 rtl/gpr_access_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gpr_access_ctrl_pkg.sv
// Shared constants and FSM state encoding for the GPR access controller.
package gpr_access_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_OPER     = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_WRITE    = 3'd4
    } state_e;

endpackage

// File: rtl/gpr_bypass_mux.sv
// Operand forwarding for back-to-back ops when GPR_BYPASS_EN is defined.
// A new op captured during a write-back sees pre-write register data, so a
// per-operand flag remembers which sources must take the held result instead.
`ifdef GPR_BYPASS_EN
module gpr_bypass_mux
    import gpr_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              in_write,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [REG_AW-1:0] rc_q,
    input  logic [DATA_W-1:0] held_lo,
    input  logic [DATA_W-1:0] gpr_a_in,
    input  logic [DATA_W-1:0] gpr_b_in,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    logic fwd_a_q, fwd_a_d;
    logic fwd_b_q, fwd_b_d;

    // Flags are set only when the capture overlaps a write to the same register
    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (load) begin
            fwd_a_d = in_write && (instr_ra == rc_q);
            fwd_b_d = in_write && (instr_rb == rc_q);
        end
    end

    // Forward flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= 1'b0;
            fwd_b_q <= 1'b0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Operand select between the register file and the held result
    always_comb begin
        op_a = fwd_a_q ? held_lo : gpr_a_in;
        op_b = fwd_b_q ? held_lo : gpr_b_in;
    end

endmodule
`endif

// File: rtl/gpr_access_ctrl.sv
// Initiator-side sequencer for the GPR file: read, execute handshake, write-back.
// Optional macro GPR_BYPASS_EN overlaps the next read with the current write.
module gpr_access_ctrl
    import gpr_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [REG_AW-1:0] instr_ra,
    input  logic [REG_AW-1:0] instr_rb,
    input  logic [REG_AW-1:0] instr_rc,
    input  logic              instr_wb,
    output logic              gpr_read_en,
    output logic              gpr_write_en,
    output logic [REG_AW-1:0] gpr_ra_num,
    output logic [REG_AW-1:0] gpr_rb_num,
    output logic [REG_AW-1:0] gpr_rc_num,
    input  logic [DATA_W-1:0] gpr_a_in,
    input  logic [DATA_W-1:0] gpr_b_in,
    output logic [DATA_W-1:0] gpr_c_out,
    output logic [DATA_W-1:0] gpr_mulhigh_out,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_lo,
    input  logic [DATA_W-1:0] res_hi
);

    state_e            state_q, state_d;
    logic [REG_AW-1:0] ra_q, ra_d;
    logic [REG_AW-1:0] rb_q, rb_d;
    logic [REG_AW-1:0] rc_q, rc_d;
    logic              wb_q, wb_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] oper_a, oper_b;
`ifdef GPR_BYPASS_EN
    logic              fwd_load;
`endif

`ifdef GPR_BYPASS_EN
    gpr_bypass_mux u_bypass (
        .clk      (clk),
        .rst      (rst),
        .load     (fwd_load),
        .in_write (state_q == ST_WRITE),
        .instr_ra (instr_ra),
        .instr_rb (instr_rb),
        .rc_q     (rc_q),
        .held_lo  (lo_q),
        .gpr_a_in (gpr_a_in),
        .gpr_b_in (gpr_b_in),
        .op_a     (oper_a),
        .op_b     (oper_b)
    );
`else
    // Register file holds its outputs while read_en is low, so pass straight through
    always_comb begin
        oper_a = gpr_a_in;
        oper_b = gpr_b_in;
    end
`endif

    // Next-state, capture and output decode; outputs forced low during reset
    always_comb begin
        state_d         = state_q;
        ra_d            = ra_q;
        rb_d            = rb_q;
        rc_d            = rc_q;
        wb_d            = wb_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        instr_ready     = 1'b0;
        gpr_read_en     = 1'b0;
        gpr_write_en    = 1'b0;
        gpr_ra_num      = '0;
        gpr_rb_num      = '0;
        gpr_rc_num      = '0;
        gpr_c_out       = '0;
        gpr_mulhigh_out = '0;
        op_valid        = 1'b0;
        op_a            = '0;
        op_b            = '0;
        res_ready       = 1'b0;
`ifdef GPR_BYPASS_EN
        fwd_load        = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ra_d    = instr_ra;
                    rb_d    = instr_rb;
                    rc_d    = instr_rc;
                    wb_d    = instr_wb;
                    state_d = ST_READ;
`ifdef GPR_BYPASS_EN
                    fwd_load = 1'b1;
`endif
                end
            end
            ST_READ: begin
                gpr_read_en = 1'b1;
                gpr_ra_num  = ra_q;
                gpr_rb_num  = rb_q;
                state_d     = ST_OPER;
            end
            ST_OPER: begin
                op_valid = 1'b1;
                op_a     = oper_a;
                op_b     = oper_b;
                if (op_ready) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    lo_d    = res_lo;
                    hi_d    = res_hi;
                    state_d = wb_q ? ST_WRITE : ST_IDLE;
                end
            end
            ST_WRITE: begin
                gpr_write_en    = 1'b1;
                gpr_rc_num      = rc_q;
                gpr_c_out       = lo_q;
                gpr_mulhigh_out = hi_q;
                state_d         = ST_IDLE;
`ifdef GPR_BYPASS_EN
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ra_d        = instr_ra;
                    rb_d        = instr_rb;
                    rc_d        = instr_rc;
                    wb_d        = instr_wb;
                    fwd_load    = 1'b1;
                    gpr_read_en = 1'b1;
                    gpr_ra_num  = instr_ra;
                    gpr_rb_num  = instr_rb;
                    state_d     = ST_OPER;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            instr_ready     = 1'b0;
            gpr_read_en     = 1'b0;
            gpr_write_en    = 1'b0;
            gpr_ra_num      = '0;
            gpr_rb_num      = '0;
            gpr_rc_num      = '0;
            gpr_c_out       = '0;
            gpr_mulhigh_out = '0;
            op_valid        = 1'b0;
            op_a            = '0;
            op_b            = '0;
            res_ready       = 1'b0;
`ifdef GPR_BYPASS_EN
            fwd_load        = 1'b0;
`endif
        end
    end

    // State and captured operation registers; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            wb_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            wb_q    <= wb_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule
